pc_gen_btb: RTL

Parametrised fetch-PC generator for the pipelined core. It holds the fetch PC and selects the next PC from four sources, in priority order: exception vector, EX-stage redirect, BTB-predicted target, and sequential PC+4. It contains a direct-mapped branch target buffer with 2-bit saturating counters, trained from EX-stage branch resolution. It sits at the head of IF and feeds the instruction memory and the IF/ID register.

---
 rtl/pc_gen_btb.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pc_gen_btb.sv
// Fetch-PC generator: exception/redirect/BTB/sequential next-PC selection plus a
// direct-mapped branch target buffer with 2-bit saturating counters.
module pc_gen_btb #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] EXC_VEC   = 32'h8000_0180,
  parameter int              BTB_DEPTH = 16,
  localparam int             IDX_W     = $clog2(BTB_DEPTH),
  localparam int             TAG_W     = XLEN - IDX_W - 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_pc_write,
  input  logic            i_exc_valid,
  input  logic            i_flush_valid,
  input  logic [XLEN-1:0] i_flush_pc,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_taken,
  input  logic [XLEN-1:0] i_upd_target,
  output logic [XLEN-1:0] o_pc,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target
);

  localparam logic [XLEN-1:0] RST_PC = {RESET_VEC[XLEN-1:2], 2'b00};
  localparam logic [XLEN-1:0] EXC_PC = {EXC_VEC[XLEN-1:2], 2'b00};

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pc_d;
  logic [BTB_DEPTH-1:0] valid_q;
  logic [1:0]       ctr_q [BTB_DEPTH];
  logic [TAG_W-1:0] tag_q [BTB_DEPTH];
  logic [XLEN-3:0]  tgt_q [BTB_DEPTH];

  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic             lk_hit_s;
  logic             pred_taken_s;
  logic [XLEN-1:0]  pred_target_s;

  logic [IDX_W-1:0] upd_idx_s;
  logic [TAG_W-1:0] upd_tag_s;
  logic             upd_hit_s;
  logic [1:0]       upd_ctr_s;
  logic [1:0]       ctr_new_s;
  logic             ctr_we_s;
  logic             alloc_s;
  logic             tgt_we_s;
  logic             unused_s;

  // Lookup for the current fetch PC; valid gates the uninitialised tag/target storage.
  assign lk_idx_s      = pc_q[IDX_W+1:2];
  assign lk_tag_s      = pc_q[XLEN-1:IDX_W+2];
  assign lk_hit_s      = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
  assign pred_taken_s  = lk_hit_s && ctr_q[lk_idx_s][1];
  assign pred_target_s = pred_taken_s ? {tgt_q[lk_idx_s], 2'b00} : {XLEN{1'b0}};

  assign o_pc          = pc_q;
  assign o_pred_taken  = pred_taken_s;
  assign o_pred_target = pred_target_s;

  assign upd_idx_s = i_upd_pc[IDX_W+1:2];
  assign upd_tag_s = i_upd_pc[XLEN-1:IDX_W+2];
  assign upd_hit_s = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);
  assign upd_ctr_s = ctr_q[upd_idx_s];

  assign unused_s = ^{i_flush_pc[1:0], i_upd_pc[1:0], i_upd_target[1:0]};

  // Next-PC selection: exception > redirect > stall > prediction > sequential.
  always_comb begin
    pc_d = pc_q;
    if (i_exc_valid) begin
      pc_d = EXC_PC;
    end else if (i_flush_valid) begin
      pc_d = {i_flush_pc[XLEN-1:2], 2'b00};
    end else if (!i_pc_write) begin
      pc_d = pc_q;
    end else if (pred_taken_s) begin
      pc_d = pred_target_s;
    end else begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RST_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Training decode: counter step on a hit, allocation on a taken miss.
  always_comb begin
    ctr_we_s  = 1'b0;
    alloc_s   = 1'b0;
    tgt_we_s  = 1'b0;
    ctr_new_s = upd_ctr_s;
    if (i_upd_valid) begin
      if (upd_hit_s) begin
        ctr_we_s = 1'b1;
        tgt_we_s = i_upd_taken;
        if (i_upd_taken) begin
          ctr_new_s = (upd_ctr_s == 2'b11) ? 2'b11 : (upd_ctr_s + 2'b01);
        end else begin
          ctr_new_s = (upd_ctr_s == 2'b00) ? 2'b00 : (upd_ctr_s - 2'b01);
        end
      end else if (i_upd_taken) begin
        ctr_we_s  = 1'b1;
        alloc_s   = 1'b1;
        tgt_we_s  = 1'b1;
        ctr_new_s = 2'b10;
      end else begin
        ctr_we_s = 1'b0;
      end
    end else begin
      ctr_we_s = 1'b0;
    end
  end

  // Valid bits and counters are the only BTB state cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= {BTB_DEPTH{1'b0}};
      for (int i = 0; i < BTB_DEPTH; i++) begin
        ctr_q[i] <= 2'b00;
      end
    end else if (ctr_we_s) begin
      ctr_q[upd_idx_s] <= ctr_new_s;
      if (alloc_s) begin
        valid_q[upd_idx_s] <= 1'b1;
      end
    end
  end

  // Tag and target payload storage.
  always_ff @(posedge clk) begin
    if (alloc_s) begin
      tag_q[upd_idx_s] <= upd_tag_s;
    end
    if (tgt_we_s) begin
      tgt_q[upd_idx_s] <= i_upd_target[XLEN-1:2];
    end
  end

endmodule
